pcs_miss_sequencer: RTL and testbench

//  Sequences the memory-side work of one cache miss for the pcs cache: an optional dirty-victim

---
 rtl/pcs_miss_sequencer.sv | 92 +++++++++
 tb/tb_pcs_miss_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/pcs_miss_sequencer.sv
// pcs_miss_sequencer: runs one cache miss against memory, first the optional dirty writeback and then the line fill, with a response watchdog
module pcs_miss_sequencer #(
  parameter int TAG_SIZE        = 24,
  parameter int SET_BITS        = 4,
  parameter int OFFSET_BITS     = 5,
  parameter int CACHE_LINE_SIZE = 256,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       miss_req,
  input  logic [31:0]                miss_addr,
  input  logic                       victim_dirty,
  input  logic [TAG_SIZE-2:0]        victim_tag,
  input  logic [CACHE_LINE_SIZE-1:0] victim_line,
  input  logic                       mem_resp,
  input  logic [CACHE_LINE_SIZE-1:0] mem_rdata,
  output logic                       mem_read,
  output logic                       mem_write,
  output logic [31:0]                mem_addr,
  output logic [CACHE_LINE_SIZE-1:0] mem_wdata,
  output logic [CACHE_LINE_SIZE-1:0] fill_line,
  output logic                       fill_valid,
  output logic                       seq_busy,
  output logic                       seq_err
);
  typedef enum logic [2:0] {IDLE, WB_REQ, WB_WAIT, FILL_REQ, FILL_WAIT, DONE, ERR} state_t;
  state_t                     state_q, state_d;
  logic [7:0]                 cnt_q, cnt_d, cnt_inc;
  logic [31:0]                addr_q;
  logic [TAG_SIZE-2:0]        tag_q;
  logic [CACHE_LINE_SIZE-1:0] line_q, fill_q;
  logic [31:0]                wb_addr, fill_addr;
  logic                       wb_phase, fill_phase, timed_out;
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
  assign timed_out  = cnt_inc >= 8'(TIMEOUT);
  assign wb_addr    = {tag_q, addr_q[OFFSET_BITS+SET_BITS-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
  assign fill_addr  = addr_q & ~((32'd1 << OFFSET_BITS) - 32'd1);
  assign wb_phase   = (state_q == WB_REQ) || (state_q == WB_WAIT);
  assign fill_phase = (state_q == FILL_REQ) || (state_q == FILL_WAIT);
  assign mem_write  = state_q == WB_REQ;
  assign mem_read   = state_q == FILL_REQ;
  assign mem_addr   = wb_phase ? wb_addr : fill_phase ? fill_addr : '0;
  assign mem_wdata  = wb_phase ? line_q : '0;
  assign fill_line  = fill_q;
  assign fill_valid = state_q == DONE;
  assign seq_busy   = state_q != IDLE;
  assign seq_err    = state_q == ERR;
  // next state and watchdog count; a response always beats a same-cycle timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:      if (miss_req) state_d = victim_dirty ? WB_REQ : FILL_REQ;
      WB_REQ:    begin state_d = WB_WAIT; cnt_d = '0; end
      WB_WAIT:   if (mem_resp) state_d = FILL_REQ;
                 else begin cnt_d = cnt_inc; state_d = timed_out ? ERR : WB_WAIT; end
      FILL_REQ:  begin state_d = FILL_WAIT; cnt_d = '0; end
      FILL_WAIT: if (mem_resp) state_d = DONE;
                 else begin cnt_d = cnt_inc; state_d = timed_out ? ERR : FILL_WAIT; end
      DONE:      state_d = IDLE;
      default:   state_d = state_q;
    endcase
  end
  // state and watchdog registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  // capture the miss context once in IDLE so later input changes cannot disturb the sequence
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      tag_q  <= '0;
      line_q <= '0;
    end else if (state_q == IDLE && miss_req) begin
      addr_q <= miss_addr;
      tag_q  <= victim_tag;
      line_q <= victim_line;
    end
  end
  // register the returned line on the fill response
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fill_q <= '0;
    else if (state_q == FILL_WAIT && mem_resp) fill_q <= mem_rdata;
  end
endmodule

// File: tb/tb_pcs_miss_sequencer.sv
// tb_pcs_miss_sequencer: directed checks of the miss sequencer with a short watchdog
module tb_pcs_miss_sequencer;
  logic         clk = 1'b0, rst = 1'b0;
  logic         miss_req = 1'b0, victim_dirty = 1'b0, mem_resp = 1'b0;
  logic [31:0]  miss_addr = '0;
  logic [22:0]  victim_tag = '0;
  logic [255:0] victim_line = '0, mem_rdata = '0;
  logic         mem_read, mem_write, fill_valid, seq_busy, seq_err;
  logic [31:0]  mem_addr;
  logic [255:0] mem_wdata, fill_line;
  int n_vec = 0, n_err = 0, rd_cnt = 0, wr_cnt = 0, fv_cnt = 0;
  localparam logic [255:0] LINE_A5 = {32{8'hA5}};
  localparam logic [255:0] D1 = {8{32'hDEADBEEF}};
  localparam logic [255:0] D2 = {8{32'h01234567}};

  pcs_miss_sequencer #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst), .miss_req(miss_req), .miss_addr(miss_addr),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag), .victim_line(victim_line),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .fill_line(fill_line),
    .fill_valid(fill_valid), .seq_busy(seq_busy), .seq_err(seq_err));

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_read) rd_cnt++;
    if (mem_write) wr_cnt++;
    if (fill_valid) fv_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    tick();
    tick();
    n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0) begin n_err++; $display("FAIL reset_req rd=%b wr=%b expected 0", mem_read, mem_write); end
    n_vec++; if (mem_addr !== 32'h0 || mem_wdata !== 256'h0) begin n_err++; $display("FAIL reset_addr addr=%h expected 0", mem_addr); end
    n_vec++; if (fill_line !== 256'h0 || fill_valid !== 1'b0) begin n_err++; $display("FAIL reset_fill fv=%b expected 0", fill_valid); end
    n_vec++; if (seq_busy !== 1'b0 || seq_err !== 1'b0) begin n_err++; $display("FAIL reset_status busy=%b err=%b expected 0", seq_busy, seq_err); end
    rst = 1'b1;
    tick();
    n_vec++; if (seq_busy !== 1'b0) begin n_err++; $display("FAIL reset_idle busy=%b expected 0", seq_busy); end
  endtask

  task automatic test_clean_miss;
    rd_cnt = 0; wr_cnt = 0; fv_cnt = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_dirty = 1'b0;
    tick();
    miss_req = 1'b0; miss_addr = 32'hFFFF_FFFF;
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1220) begin n_err++; $display("FAIL clean_req rd=%b addr=%h expected 1 00001220", mem_read, mem_addr); end
    n_vec++; if (seq_busy !== 1'b1) begin n_err++; $display("FAIL clean_busy busy=%b expected 1", seq_busy); end
    tick();
    n_vec++; if (mem_read !== 1'b0 || mem_addr !== 32'h0000_1220) begin n_err++; $display("FAIL clean_hold rd=%b addr=%h expected 0 00001220", mem_read, mem_addr); end
    tick();
    tick();
    mem_resp = 1'b1; mem_rdata = D1;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1 || fill_line !== D1) begin n_err++; $display("FAIL clean_fill fv=%b line=%h expected 1 %h", fill_valid, fill_line, D1); end
    tick();
    n_vec++; if (fill_valid !== 1'b0 || seq_busy !== 1'b0) begin n_err++; $display("FAIL clean_end fv=%b busy=%b expected 0 0", fill_valid, seq_busy); end
    n_vec++; if (rd_cnt !== 1 || wr_cnt !== 0 || fv_cnt !== 1) begin n_err++; $display("FAIL clean_pulses rd=%0d wr=%0d fv=%0d expected 1 0 1", rd_cnt, wr_cnt, fv_cnt); end
  endtask

  task automatic test_dirty_miss;
    rd_cnt = 0; wr_cnt = 0; fv_cnt = 0;
    miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_dirty = 1'b1;
    victim_tag = 23'h7F; victim_line = LINE_A5;
    tick();
    miss_req = 1'b0; victim_tag = '0; victim_line = '0; victim_dirty = 1'b0;
    n_vec++; if (mem_write !== 1'b1 || mem_read !== 1'b0) begin n_err++; $display("FAIL dirty_wreq wr=%b rd=%b expected 1 0", mem_write, mem_read); end
    n_vec++; if (mem_addr !== 32'h0000_FE20 || mem_wdata !== LINE_A5) begin n_err++; $display("FAIL dirty_waddr addr=%h expected 0000fe20", mem_addr); end
    tick();
    n_vec++; if (mem_write !== 1'b0 || mem_addr !== 32'h0000_FE20 || mem_wdata !== LINE_A5) begin n_err++; $display("FAIL dirty_whold wr=%b addr=%h expected 0 0000fe20", mem_write, mem_addr); end
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1220 || mem_write !== 1'b0) begin n_err++; $display("FAIL dirty_rreq rd=%b addr=%h expected 1 00001220", mem_read, mem_addr); end
    tick();
    tick();
    mem_resp = 1'b1; mem_rdata = D2;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1 || fill_line !== D2) begin n_err++; $display("FAIL dirty_fill fv=%b line=%h expected 1 %h", fill_valid, fill_line, D2); end
    tick();
    n_vec++; if (rd_cnt !== 1 || wr_cnt !== 1 || fv_cnt !== 1) begin n_err++; $display("FAIL dirty_pulses rd=%0d wr=%0d fv=%0d expected 1 1 1", rd_cnt, wr_cnt, fv_cnt); end
  endtask

  task automatic test_spurious_resp;
    mem_resp = 1'b1;
    tick();
    n_vec++; if (seq_busy !== 1'b0 || mem_read !== 1'b0 || mem_write !== 1'b0) begin n_err++; $display("FAIL spur_idle busy=%b rd=%b wr=%b expected 0 0 0", seq_busy, mem_read, mem_write); end
    mem_resp = 1'b0;
    miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_dirty = 1'b1; victim_tag = 23'h7F; victim_line = LINE_A5;
    tick();
    miss_req = 1'b0; victim_dirty = 1'b0;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_vec++; if (mem_read !== 1'b0 || mem_write !== 1'b0 || seq_busy !== 1'b1 || mem_addr !== 32'h0000_FE20) begin n_err++; $display("FAIL spur_wbreq rd=%b wr=%b busy=%b addr=%h expected 0 0 1 0000fe20", mem_read, mem_write, seq_busy, mem_addr); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    n_vec++; if (mem_read !== 1'b1) begin n_err++; $display("FAIL spur_resume rd=%b expected 1", mem_read); end
    tick();
    mem_resp = 1'b1; mem_rdata = D1;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    tick();
  endtask

  task automatic test_watchdog;
    miss_req = 1'b1; miss_addr = 32'h0000_0040; victim_dirty = 1'b0;
    tick();
    miss_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    n_vec++; if (seq_err !== 1'b0 || seq_busy !== 1'b1) begin n_err++; $display("FAIL wd_before err=%b busy=%b expected 0 1", seq_err, seq_busy); end
    tick();
    n_vec++; if (seq_err !== 1'b1 || mem_read !== 1'b0 || mem_addr !== 32'h0 || seq_busy !== 1'b1) begin n_err++; $display("FAIL wd_err err=%b rd=%b addr=%h busy=%b expected 1 0 0 1", seq_err, mem_read, mem_addr, seq_busy); end
    miss_req = 1'b1; mem_resp = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    miss_req = 1'b0; mem_resp = 1'b0;
    n_vec++; if (seq_err !== 1'b1 || mem_read !== 1'b0 || mem_write !== 1'b0) begin n_err++; $display("FAIL wd_sticky err=%b rd=%b wr=%b expected 1 0 0", seq_err, mem_read, mem_write); end
    rst = 1'b0;
    #1;
    rst = 1'b1;
    tick();
    n_vec++; if (seq_err !== 1'b0) begin n_err++; $display("FAIL wd_clear err=%b expected 0", seq_err); end
    miss_req = 1'b1; miss_addr = 32'h0000_0040;
    tick();
    miss_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    mem_resp = 1'b1; mem_rdata = D2;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1 || seq_err !== 1'b0 || fill_line !== D2) begin n_err++; $display("FAIL wd_race fv=%b err=%b expected 1 0", fill_valid, seq_err); end
    tick();
  endtask

  task automatic test_async_reset;
    miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_dirty = 1'b1; victim_tag = 23'h7F; victim_line = LINE_A5;
    tick();
    miss_req = 1'b0; victim_dirty = 1'b0;
    tick();
    n_vec++; if (seq_busy !== 1'b1 || mem_addr !== 32'h0000_FE20) begin n_err++; $display("FAIL ar_wbwait busy=%b addr=%h expected 1 0000fe20", seq_busy, mem_addr); end
    rst = 1'b0;
    #1;
    n_vec++; if (seq_busy !== 1'b0 || mem_addr !== 32'h0 || mem_wdata !== 256'h0 || fill_line !== 256'h0) begin n_err++; $display("FAIL ar_async busy=%b addr=%h expected 0 0", seq_busy, mem_addr); end
    n_vec++; if (mem_write !== 1'b0 || mem_read !== 1'b0 || fill_valid !== 1'b0 || seq_err !== 1'b0) begin n_err++; $display("FAIL ar_async_ctl wr=%b rd=%b fv=%b err=%b expected 0", mem_write, mem_read, fill_valid, seq_err); end
    rst = 1'b1;
    miss_req = 1'b1; miss_addr = 32'h0000_1234;
    tick();
    miss_req = 1'b0;
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_1220) begin n_err++; $display("FAIL ar_after_req rd=%b addr=%h expected 1 00001220", mem_read, mem_addr); end
    tick();
    mem_resp = 1'b1; mem_rdata = D1;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1 || fill_line !== D1) begin n_err++; $display("FAIL ar_after_fill fv=%b line=%h expected 1 %h", fill_valid, fill_line, D1); end
    tick();
  endtask

  task automatic test_back_to_back;
    miss_req = 1'b1; miss_addr = 32'h0000_1234; victim_dirty = 1'b0;
    tick();
    miss_addr = 32'h0000_5678;
    tick();
    mem_resp = 1'b1; mem_rdata = D1;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1) begin n_err++; $display("FAIL b2b_done fv=%b expected 1", fill_valid); end
    tick();
    n_vec++; if (seq_busy !== 1'b0 || mem_read !== 1'b0) begin n_err++; $display("FAIL b2b_bubble busy=%b rd=%b expected 0 0", seq_busy, mem_read); end
    tick();
    miss_req = 1'b0;
    n_vec++; if (mem_read !== 1'b1 || mem_addr !== 32'h0000_5660) begin n_err++; $display("FAIL b2b_second rd=%b addr=%h expected 1 00005660", mem_read, mem_addr); end
    tick();
    mem_resp = 1'b1; mem_rdata = D2;
    tick();
    mem_resp = 1'b0; mem_rdata = '0;
    n_vec++; if (fill_valid !== 1'b1 || fill_line !== D2) begin n_err++; $display("FAIL b2b_fill2 fv=%b line=%h expected 1 %h", fill_valid, fill_line, D2); end
    tick();
  endtask

  initial begin
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_spurious_resp();
    test_watchdog();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
